ipd_hazard_scoreboard: RTL

Read-after-write interlock scheduler for the in-order pipeline. It sits beside the ID stage and consumes the pre-decoded register numbers that IPD forwards on `IPD_to_ID_bus`: read addresses 1/2 and the write address. It tracks every instruction issued from ID to EXE in an in-order destination FIFO and keeps a per-register pending count. It tells ID to hold while a source register still has an unretired producer.

---
 rtl/ipd_hazard_scoreboard_pkg.sv | 16 +
 rtl/ipd_hazard_scoreboard_sb_tag_fifo.sv | 60 ++++++
 rtl/ipd_hazard_scoreboard.sv | 96 +++++++++
 3 files changed

// File: rtl/ipd_hazard_scoreboard_pkg.sv
// Shared constants and types for the read-after-write hazard scoreboard.
package ipd_hazard_scoreboard_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 1 << REG_ADDR_W;
   localparam int SB_DEPTH   = 4;
   localparam int SB_CNT_W   = 3;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   // r0 is hard-wired zero, so it never creates or resolves a dependency.
   function automatic logic is_tracked(input reg_addr_t addr);
      return addr != '0;
   endfunction

endpackage

// File: rtl/ipd_hazard_scoreboard_sb_tag_fifo.sv
// In-order FIFO of destination-register tags for instructions between ID issue and WB retire.
// The caller guarantees push/pop legality; this block only stores and counts.
module sb_tag_fifo
   import ipd_hazard_scoreboard_pkg::*;
#(
   parameter int DEPTH = SB_DEPTH,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             push,
   input  logic             pop,
   input  reg_addr_t        push_tag,
   output reg_addr_t        head,
   output logic [PTR_W:0]   count,
   output logic             full,
   output logic             empty
);

   reg_addr_t        mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   // Tag storage is pure data and needs no reset; the count qualifies every read.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_tag;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= PTR_W'(wr_ptr + 1'b1);
         if (pop)  rd_ptr <= PTR_W'(rd_ptr + 1'b1);
      end
   end

   // Occupancy: simultaneous push and pop leaves it unchanged.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count <= '0;
      end else begin
         case ({push, pop})
            2'b10:   count <= (PTR_W+1)'(count + 1'b1);
            2'b01:   count <= (PTR_W+1)'(count - 1'b1);
            default: count <= count;
         endcase
      end
   end

   assign empty = (count == '0);
   assign full  = (count == (PTR_W+1)'(DEPTH));
   // Masked so the head reads as r0 whenever nothing is in flight (including after reset).
   assign head  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/ipd_hazard_scoreboard.sv
// Read-after-write interlock: tracks in-flight destinations and holds ID while a source
// register still has an unretired producer or the in-flight window is full.
module ipd_hazard_scoreboard
   import ipd_hazard_scoreboard_pkg::*;
#(
   parameter int DEPTH = SB_DEPTH,
   parameter int CNT_W = SB_CNT_W
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     id_valid,
   input  logic [REG_ADDR_W-1:0]    id_raddr1,
   input  logic [REG_ADDR_W-1:0]    id_raddr2,
   input  logic [REG_ADDR_W-1:0]    id_waddr,
   input  logic                     issue_fire,
   input  logic                     retire_valid,
   output logic                     id_stall,
   output logic                     sb_full,
   output logic [$clog2(DEPTH):0]   sb_count,
   output logic [REG_ADDR_W-1:0]    retire_waddr,
   output logic                     sb_error
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [CNT_W-1:0] pend [NUM_REGS];
   logic             haz1;
   logic             haz2;
   logic             fifo_empty;
   logic             issue_ok;
   logic             retire_ok;
   logic             issue_bad;
   logic             retire_bad;
   logic             inc_en;
   logic             dec_en;
   reg_addr_t        head;

   sb_tag_fifo #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_fifo (
      .clk      (clk),
      .resetn   (resetn),
      .push     (issue_ok),
      .pop      (retire_ok),
      .push_tag (id_waddr),
      .head     (head),
      .count    (sb_count),
      .full     (sb_full),
      .empty    (fifo_empty)
   );

   // Hazard detect and operation legality; illegal operations are dropped and flagged.
   always_comb begin
      haz1       = is_tracked(id_raddr1) && (pend[id_raddr1] != '0);
      haz2       = is_tracked(id_raddr2) && (pend[id_raddr2] != '0);
      id_stall   = id_valid && (haz1 || haz2 || sb_full);
      // Full stall uses pre-edge occupancy: a same-cycle retire rescues the issue only
      // when ID was not already told to hold.
      issue_bad  = issue_fire && (id_stall || (sb_full && !retire_valid));
      retire_bad = retire_valid && fifo_empty;
      issue_ok   = issue_fire && !issue_bad;
      retire_ok  = retire_valid && !retire_bad;
      inc_en     = issue_ok && is_tracked(id_waddr);
      dec_en     = retire_ok && is_tracked(head);
   end

   // Per-register pending counts; a register issued and retired together nets to no change.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            pend[r] <= '0;
         end
      end else begin
         for (int r = 1; r < NUM_REGS; r++) begin
            if ((inc_en && (id_waddr == REG_ADDR_W'(r))) && !(dec_en && (head == REG_ADDR_W'(r)))) begin
               pend[r] <= CNT_W'(pend[r] + 1'b1);
            end else if (!(inc_en && (id_waddr == REG_ADDR_W'(r))) && (dec_en && (head == REG_ADDR_W'(r)))) begin
               pend[r] <= CNT_W'(pend[r] - 1'b1);
            end
         end
      end
   end

   // Sticky protocol error, cleared only by reset.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sb_error <= 1'b0;
      end else if (issue_bad || retire_bad) begin
         sb_error <= 1'b1;
      end
   end

   assign retire_waddr = head;

endmodule
